// File: rtl/conv_weight_loader_pkg.sv
// Shared types and sizing for the first-stage conv weight loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package conv_weight_loader_pkg;

  localparam int CNT_W             = 7;
  localparam int KERNEL_NUM        = 81;
  localparam int BIAS_NUM          = 12;
  localparam int DEQUANT_SCALE_NUM = 24;

  // Kernel, bias and scale words are followed by a single requant config word.
  function automatic int weights_num(input int k, input int b, input int s);
    return k + b + s + 1;
  endfunction

  localparam int WEIGHTS_NUM = weights_num(KERNEL_NUM, BIAS_NUM, DEQUANT_SCALE_NUM);

  localparam int KERNEL_END = KERNEL_NUM;
  localparam int BIAS_END   = KERNEL_END + BIAS_NUM;
  localparam int SCALE_END  = BIAS_END + DEQUANT_SCALE_NUM;

  typedef enum logic [1:0] {LD_IDLE, LD_FETCH, LD_DRAIN, LD_DONE} ld_state_e;
  typedef enum logic [1:0] {RGN_KERNEL, RGN_BIAS, RGN_SCALE, RGN_CFG} rgn_e;

  function automatic rgn_e region_of(input logic [CNT_W-1:0] r,
                                     input logic [CNT_W-1:0] kend,
                                     input logic [CNT_W-1:0] bend,
                                     input logic [CNT_W-1:0] send);
    if (r < kend) return RGN_KERNEL;
    if (r < bend) return RGN_BIAS;
    if (r < send) return RGN_SCALE;
    return RGN_CFG;
  endfunction

endpackage

// File: rtl/weight_resp_router.sv
// Steers each accepted response beat to kernel/bias/scale RAM or the config register.
// Latency: 1 cycle from beat to registered strobe, index and data.
// Backpressure: none; every accepted beat is written the following cycle.
module weight_resp_router
  import conv_weight_loader_pkg::*;
#(
  parameter int               DW   = 64,
  parameter logic [CNT_W-1:0] KEND = CNT_W'(KERNEL_END),
  parameter logic [CNT_W-1:0] BEND = CNT_W'(BIAS_END),
  parameter logic [CNT_W-1:0] SEND = CNT_W'(SCALE_END)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             beat_vld,
  input  logic [CNT_W-1:0] resp_cnt,
  input  logic [DW-1:0]    beat_dat,
  output logic [DW-1:0]    wr_data,
  output logic             kernel_we,
  output logic [6:0]       kernel_addr,
  output logic             bias_we,
  output logic [3:0]       bias_addr,
  output logic             scale_we,
  output logic [4:0]       scale_addr,
  output logic [DW-1:0]    cfg
);

  rgn_e rgn;
  assign rgn = region_of(resp_cnt, KEND, BEND, SEND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_data     <= '0;
      kernel_we   <= 1'b0;
      kernel_addr <= '0;
      bias_we     <= 1'b0;
      bias_addr   <= '0;
      scale_we    <= 1'b0;
      scale_addr  <= '0;
      cfg         <= '0;
    end else begin
      kernel_we <= beat_vld && (rgn == RGN_KERNEL);
      bias_we   <= beat_vld && (rgn == RGN_BIAS);
      scale_we  <= beat_vld && (rgn == RGN_SCALE);
      if (beat_vld) begin
        wr_data <= beat_dat;
        case (rgn)
          RGN_KERNEL: kernel_addr <= 7'(resp_cnt);
          RGN_BIAS:   bias_addr   <= 4'(resp_cnt - KEND);
          RGN_SCALE:  scale_addr  <= 5'(resp_cnt - BEND);
          default:    cfg         <= beat_dat;
        endcase
      end
    end
  end

endmodule

// File: rtl/conv_weight_loader.sv
// Streams the first conv stage's weights from memory into kernel/bias/scale RAMs and cfg.
// Latency: RAM write 1 cycle after each response beat; done_o 1 cycle after the final beat.
// Backpressure: request held until granted; at most pMAX_OUTSTANDING reads in flight.
module conv_weight_loader
  import conv_weight_loader_pkg::*;
#(
  parameter logic [31:0] pWEIGHT_BASE_ADDR  = 32'h4000_0000,
  parameter int          pWEIGHT_DATA_WIDTH = 64,
  parameter int          pKERNEL_NUM        = KERNEL_NUM,
  parameter int          pBIAS_NUM          = BIAS_NUM,
  parameter int          pDEQUANT_SCALE_NUM = DEQUANT_SCALE_NUM,
  parameter int          pMAX_OUTSTANDING   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_i,
  output logic                          rd_req_o,
  output logic [31:0]                   rd_addr_o,
  input  logic                          rd_gnt_i,
  input  logic                          rd_data_valid_i,
  input  logic [pWEIGHT_DATA_WIDTH-1:0] rd_data_i,
  output logic [pWEIGHT_DATA_WIDTH-1:0] wr_data_o,
  output logic                          kernel_we_o,
  output logic [6:0]                    kernel_addr_o,
  output logic                          bias_we_o,
  output logic [3:0]                    bias_addr_o,
  output logic                          scale_we_o,
  output logic [4:0]                    scale_addr_o,
  output logic [pWEIGHT_DATA_WIDTH-1:0] cfg_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          weights_valid_o
);

  localparam int               N     = weights_num(pKERNEL_NUM, pBIAS_NUM, pDEQUANT_SCALE_NUM);
  localparam int               OW    = $clog2(pMAX_OUTSTANDING) + 1;
  localparam logic [CNT_W-1:0] N_C   = CNT_W'(N);
  localparam logic [OW-1:0]    MAX_C = OW'(pMAX_OUTSTANDING);

  ld_state_e        state, state_nxt;
  logic [CNT_W-1:0] req_cnt, req_nxt, resp_cnt, resp_nxt;
  logic [OW-1:0]    out_cnt, out_nxt;
  logic             wv_q, wv_nxt;
  logic             grant, beat_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LD_IDLE;
      req_cnt  <= '0;
      resp_cnt <= '0;
      out_cnt  <= '0;
      wv_q     <= 1'b0;
    end else begin
      state    <= state_nxt;
      req_cnt  <= req_nxt;
      resp_cnt <= resp_nxt;
      out_cnt  <= out_nxt;
      wv_q     <= wv_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_nxt   = req_cnt;
    resp_nxt  = resp_cnt;
    out_nxt   = out_cnt;
    wv_nxt    = wv_q;
    rd_req_o  = 1'b0;
    grant     = 1'b0;
    beat_vld  = 1'b0;
    case (state)
      LD_IDLE: begin
        if (start_i) begin
          state_nxt = LD_FETCH;
          req_nxt   = '0;
          resp_nxt  = '0;
          out_nxt   = '0;
          wv_nxt    = 1'b0;
        end
      end
      LD_FETCH, LD_DRAIN: begin
        rd_req_o = (state == LD_FETCH) && (req_cnt < N_C) && (out_cnt < MAX_C);
        grant    = rd_req_o && rd_gnt_i;
        beat_vld = rd_data_valid_i && (resp_cnt < N_C);
        if (grant)    req_nxt  = req_cnt + CNT_W'(1);
        if (beat_vld) resp_nxt = resp_cnt + CNT_W'(1);
        case ({grant, beat_vld})
          2'b10:   out_nxt = out_cnt + OW'(1);
          2'b01:   out_nxt = (out_cnt != '0) ? out_cnt - OW'(1) : out_cnt;
          default: out_nxt = out_cnt;
        endcase
        // Leave DRAIN on the cycle the last beat lands so done_o follows the final write directly.
        if (state == LD_FETCH && req_nxt == N_C) state_nxt = LD_DRAIN;
        if (state == LD_DRAIN && resp_nxt == N_C) begin
          state_nxt = LD_DONE;
          wv_nxt    = 1'b1;
        end
      end
      default: state_nxt = LD_IDLE;
    endcase
  end

  assign rd_addr_o = rd_req_o ? (pWEIGHT_BASE_ADDR + {{(32-CNT_W-3){1'b0}}, req_cnt, 3'b000}) : 32'h0;
  assign busy_o          = (state == LD_FETCH) || (state == LD_DRAIN);
  assign done_o          = (state == LD_DONE);
  assign weights_valid_o = wv_q;

  weight_resp_router #(
    .DW   (pWEIGHT_DATA_WIDTH),
    .KEND (CNT_W'(pKERNEL_NUM)),
    .BEND (CNT_W'(pKERNEL_NUM + pBIAS_NUM)),
    .SEND (CNT_W'(pKERNEL_NUM + pBIAS_NUM + pDEQUANT_SCALE_NUM))
  ) u_router (
    .clk         (clk),
    .rst_n       (rst_n),
    .beat_vld    (beat_vld),
    .resp_cnt    (resp_cnt),
    .beat_dat    (rd_data_i),
    .wr_data     (wr_data_o),
    .kernel_we   (kernel_we_o),
    .kernel_addr (kernel_addr_o),
    .bias_we     (bias_we_o),
    .bias_addr   (bias_addr_o),
    .scale_we    (scale_we_o),
    .scale_addr  (scale_addr_o),
    .cfg         (cfg_o)
  );

endmodule

// File: tb/tb_conv_weight_loader.sv
// Bench for conv_weight_loader: randomized memory model driving directed load scenarios.
module tb_conv_weight_loader;

  localparam logic [31:0] BASE    = 32'h4000_0000;
  localparam int          TOTAL   = 118;
  localparam int          K_N     = 81;
  localparam int          B_N     = 12;
  localparam int          MAX_OUT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        rd_req_o;
  logic [31:0] rd_addr_o;
  logic        rd_gnt_i = 1'b0;
  logic        rd_data_valid_i = 1'b0;
  logic [63:0] rd_data_i = '0;
  logic [63:0] wr_data_o;
  logic        kernel_we_o;
  logic [6:0]  kernel_addr_o;
  logic        bias_we_o;
  logic [3:0]  bias_addr_o;
  logic        scale_we_o;
  logic [4:0]  scale_addr_o;
  logic [63:0] cfg_o;
  logic        busy_o;
  logic        done_o;
  logic        weights_valid_o;

  conv_weight_loader dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_i         (start_i),
    .rd_req_o        (rd_req_o),
    .rd_addr_o       (rd_addr_o),
    .rd_gnt_i        (rd_gnt_i),
    .rd_data_valid_i (rd_data_valid_i),
    .rd_data_i       (rd_data_i),
    .wr_data_o       (wr_data_o),
    .kernel_we_o     (kernel_we_o),
    .kernel_addr_o   (kernel_addr_o),
    .bias_we_o       (bias_we_o),
    .bias_addr_o     (bias_addr_o),
    .scale_we_o      (scale_we_o),
    .scale_addr_o    (scale_addr_o),
    .cfg_o           (cfg_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .weights_valid_o (weights_valid_o)
  );

  always #5 clk = ~clk;

  int          n_assert = 0, n_fail = 0;
  int          cyc = 0;
  int          n_grant, n_beat, n_wr, n_done, max_out;
  int          done_cyc, last_beat_cyc, last_scale_cyc;
  int          lat_lo, lat_hi, gnt_pct, stall_at = -1, stall_len, stall_cnt;
  bit          quiet = 1'b0, prev_hold = 1'b0;
  logic [31:0] prev_addr;
  logic [63:0] mem [TOTAL];
  int          resp_idx[$];
  int          resp_rdy[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},    64'(rd_req_o), 64'd0);
    chk({tag, "_addr"},   64'(rd_addr_o), 64'd0);
    chk({tag, "_we"},     64'({kernel_we_o, bias_we_o, scale_we_o}), 64'd0);
    chk({tag, "_idx"},    64'({kernel_addr_o, bias_addr_o, scale_addr_o}), 64'd0);
    chk({tag, "_wdata"},  wr_data_o, 64'd0);
    chk({tag, "_cfg"},    cfg_o, 64'd0);
    chk({tag, "_status"}, 64'({busy_o, done_o, weights_valid_o}), 64'd0);
  endtask

  // One clock: sample outputs at the falling edge, check them, then drive the memory side.
  task automatic tick();
    int  ns, ek, ea, gk, ga, idx, out_b;
    bit  gnt;
    logic [31:0] diff;
    @(negedge clk);
    cyc++;
    ns = int'(kernel_we_o) + int'(bias_we_o) + int'(scale_we_o);
    if (quiet) begin
      chk("quiet_strobe", 64'(ns), 64'd0);
      chk("quiet_busy", 64'(busy_o), 64'd0);
    end else if (ns != 0) begin
      chk("strobe_onehot", 64'(ns), 64'd1);
      if (n_wr >= TOTAL - 1) chk("extra_write", 64'(n_wr), 64'(TOTAL - 2));
      else begin
        if (n_wr < K_N)            begin ek = 0; ea = n_wr;             end
        else if (n_wr < K_N + B_N) begin ek = 1; ea = n_wr - K_N;       end
        else                       begin ek = 2; ea = n_wr - K_N - B_N; end
        gk = kernel_we_o ? 0 : (bias_we_o ? 1 : 2);
        ga = kernel_we_o ? int'(kernel_addr_o) : (bias_we_o ? int'(bias_addr_o) : int'(scale_addr_o));
        chk("wr_region", 64'(gk), 64'(ek));
        chk("wr_index", 64'(ga), 64'(ea));
        chk("wr_data", wr_data_o, mem[n_wr]);
        if (gk == 2) last_scale_cyc = cyc;
      end
      n_wr++;
    end
    if (done_o) begin
      n_done++;
      done_cyc = cyc;
      chk("done_busy", 64'(busy_o), 64'd0);
      chk("done_valid", 64'(weights_valid_o), 64'd1);
      chk("done_cfg", cfg_o, mem[TOTAL-1]);
    end
    if (prev_hold) begin
      chk("req_hold", 64'(rd_req_o), 64'd1);
      chk("addr_hold", 64'(rd_addr_o), 64'(prev_addr));
    end
    out_b = n_grant - n_beat;
    if (out_b > max_out) max_out = out_b;
    if (quiet || out_b >= MAX_OUT || n_grant >= TOTAL) chk("req_blocked", 64'(rd_req_o), 64'd0);

    gnt = int'($urandom_range(99)) < gnt_pct;
    if (rd_req_o && n_grant == stall_at && stall_cnt < stall_len) begin
      gnt = 1'b0;
      stall_cnt++;
      chk("stall_addr", 64'(rd_addr_o), 64'(BASE + 32'(8 * stall_at)));
    end
    rd_gnt_i  = gnt;
    prev_hold = rd_req_o && !gnt;
    prev_addr = rd_addr_o;
    if (rd_req_o && gnt) begin
      chk("rd_addr", 64'(rd_addr_o), 64'(BASE + 32'(8 * n_grant)));
      diff = (rd_addr_o - BASE) >> 3;
      idx  = (diff < 32'(TOTAL)) ? int'(diff) : 0;
      resp_idx.push_back(idx);
      resp_rdy.push_back(cyc + int'($urandom_range(lat_hi, lat_lo)));
      n_grant++;
    end
    if (resp_idx.size() > 0 && resp_rdy[0] <= cyc) begin
      rd_data_valid_i = 1'b1;
      rd_data_i       = mem[resp_idx[0]];
      void'(resp_idx.pop_front());
      void'(resp_rdy.pop_front());
      n_beat++;
      last_beat_cyc = cyc;
    end else begin
      rd_data_valid_i = 1'b0;
      rd_data_i       = {$urandom, $urandom};
    end
  endtask

  task automatic run_load(input string name, input bit idx_data, input int lo, input int hi,
                          input int pct, input int st_at, input int st_len,
                          input int dup_at, input int abort_at);
    bit aborted = 1'b0;
    lat_lo = lo; lat_hi = hi; gnt_pct = pct;
    stall_at = st_at; stall_len = st_len; stall_cnt = 0;
    n_grant = 0; n_beat = 0; n_wr = 0; n_done = 0; max_out = 0;
    done_cyc = -1; last_beat_cyc = -1; last_scale_cyc = -1; prev_hold = 1'b0;
    for (int i = 0; i < TOTAL; i++) mem[i] = idx_data ? 64'(i) : {$urandom, $urandom};
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk({name, "_busy_after_start"}, 64'(busy_o), 64'd1);
    chk({name, "_valid_after_start"}, 64'(weights_valid_o), 64'd0);
    for (int c = 0; c < 4000 && n_done == 0; c++) begin
      tick();
      start_i = (c == dup_at);
      if (abort_at >= 0 && n_beat >= abort_at) begin
        aborted = 1'b1;
        break;
      end
    end
    start_i = 1'b0;
    if (aborted) begin
      rst_n = 1'b0;
      #1;
      chk_all_zero({name, "_midreset"});
      quiet = 1'b1;
      prev_hold = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 60 && resp_idx.size() > 0; c++) tick();
      tick();
      tick();
      quiet = 1'b0;
    end else begin
      repeat (5) tick();
      chk({name, "_done_count"}, 64'(n_done), 64'd1);
      chk({name, "_grants"}, 64'(n_grant), 64'(TOTAL));
      chk({name, "_writes"}, 64'(n_wr), 64'(TOTAL - 1));
      chk({name, "_done_after_last_beat"}, 64'(done_cyc), 64'(last_beat_cyc + 1));
      chk({name, "_max_outstanding_ok"}, 64'(max_out <= MAX_OUT), 64'd1);
      chk({name, "_cfg_hold"}, cfg_o, mem[TOTAL-1]);
      chk({name, "_idle_status"}, 64'({busy_o, weights_valid_o}), 64'b01);
      if (idx_data) chk({name, "_done_after_scale"}, 64'(done_cyc), 64'(last_scale_cyc + 1));
    end
  endtask

  initial begin
    lat_lo = 1; lat_hi = 1; gnt_pct = 100;
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (3) tick();
    chk_all_zero("post_reset_idle");

    // Always-grant memory with fixed 2-cycle return of the word index.
    run_load("s1", 1'b1, 2, 2, 100, -1, 0, -1, -1);
    // Grant withheld for 5 cycles while request 40 is pending.
    run_load("s2", 1'b0, 2, 2, 100, 40, 5, -1, -1);
    chk("s2_stall_cycles", 64'(stall_cnt), 64'd5);
    // Long return latency: the outstanding limit becomes the throttle.
    run_load("s3", 1'b0, 20, 20, 100, -1, 0, -1, -1);
    chk("s3_max_outstanding", 64'(max_out), 64'(MAX_OUT));
    // A second start mid-load must be ignored.
    run_load("s4", 1'b0, 1, 4, 80, -1, 0, 30, -1);
    // Reset during the bias phase, stale responses still in flight, then a clean reload.
    run_load("s5", 1'b0, 8, 12, 100, -1, 0, -1, 85);
    run_load("s5_reload", 1'b0, 1, 3, 90, -1, 0, -1, -1);
    // Heavy back-pressure with grants and responses frequently landing together.
    run_load("s6", 1'b0, 1, 3, 50, -1, 0, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
